// File: rtl/suma_pkg.sv
// ============================================================================
// Module      : suma_pkg
// Description : Shared binary32 format constants and helpers for the
//               suma_de_longitudes floating-point adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package suma_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int BIAS    = 127;
    localparam int LATENCY = 3;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Significand with hidden bit, then guard/round/sticky, then carry
    localparam int MANT_W = FRAC_W + 1;
    localparam int EXT_W  = MANT_W + 3;
    localparam int SUM_W  = EXT_W + 1;
    localparam int LZC_W  = 5;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    function automatic logic fp_is_nan(input fp32_t x);
        return (x.exp == '1) && (x.frac != '0);
    endfunction

    function automatic logic fp_is_inf(input fp32_t x);
        return (x.exp == '1) && (x.frac == '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/suma_normalizer.sv
// ============================================================================
// Module      : suma_normalizer
// Description : Leading-zero count and left normalizing shift of the raw sum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module suma_normalizer
    import suma_pkg::*;
(
    input  logic [SUM_W-1:0] i_sum,
    output logic [LZC_W-1:0] o_lzc,
    output logic [SUM_W-1:0] o_norm
);

    // Ascending scan: the highest set bit is the last one to write o_lzc
    always_comb begin
        o_lzc = LZC_W'(SUM_W);
        for (int i = 0; i < SUM_W; i++) begin
            if (i_sum[i]) begin
                o_lzc = LZC_W'(SUM_W - 1 - i);
            end
        end
    end

    assign o_norm = i_sum << o_lzc;

endmodule

`default_nettype wire

// File: rtl/suma_de_longitudes.sv
// ============================================================================
// Module      : suma_de_longitudes
// Description : 3-stage AXI-Stream binary32 adder (align, add, normalize/round),
//               RNE rounding, subnormals flushed to zero.
//               Define SUMA_DE_LONGITUDES_FLAGS_EN to add m_axis_result_tuser
//               = {invalid, overflow, underflow}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module suma_de_longitudes (
    input  logic        aclk,
    input  logic        areset,
    input  logic        s_axis_a_tvalid,
    output logic        s_axis_a_tready,
    input  logic [31:0] s_axis_a_tdata,
    input  logic        s_axis_b_tvalid,
    output logic        s_axis_b_tready,
    input  logic [31:0] s_axis_b_tdata,
    output logic        m_axis_result_tvalid,
    input  logic        m_axis_result_tready,
    output logic [31:0] m_axis_result_tdata
`ifdef SUMA_DE_LONGITUDES_FLAGS_EN
    ,
    output logic [2:0]  m_axis_result_tuser
`endif
);

    import suma_pkg::*;

    logic r_out_valid;
    logic [31:0] r_out_data;
    logic w_stall, w_ready;

    assign w_stall = r_out_valid & ~m_axis_result_tready;
    assign w_ready = s_axis_a_tvalid & s_axis_b_tvalid & ~w_stall & ~areset;

    assign s_axis_a_tready      = w_ready;
    assign s_axis_b_tready      = w_ready;
    assign m_axis_result_tvalid = r_out_valid;
    assign m_axis_result_tdata  = r_out_data;

    // ---------------- Stage 1: classify, order by magnitude, align ----------
    fp32_t w_a, w_b;
    logic w_a_zero, w_b_zero, w_swap;
    logic [30:0] w_a_mag, w_b_mag;
    logic [MANT_W-1:0] w_a_mant, w_b_mant, w_big_mant, w_small_mant;
    logic [EXP_W-1:0] w_big_exp, w_small_exp, w_diff;
    logic [49:0] w_shift_ext;
    logic [EXT_W-1:0] w_small_al;
    logic w_special;
    logic [31:0] w_spec_res;

    assign w_a = s_axis_a_tdata;
    assign w_b = s_axis_b_tdata;
    assign w_a_zero = (w_a.exp == '0);
    assign w_b_zero = (w_b.exp == '0);
    assign w_a_mag  = w_a_zero ? '0 : {w_a.exp, w_a.frac};
    assign w_b_mag  = w_b_zero ? '0 : {w_b.exp, w_b.frac};
    assign w_a_mant = w_a_zero ? '0 : {1'b1, w_a.frac};
    assign w_b_mant = w_b_zero ? '0 : {1'b1, w_b.frac};
    assign w_swap   = (w_b_mag > w_a_mag);

    assign w_big_mant   = w_swap ? w_b_mant : w_a_mant;
    assign w_small_mant = w_swap ? w_a_mant : w_b_mant;
    assign w_big_exp    = w_swap ? w_b.exp  : w_a.exp;
    assign w_small_exp  = w_swap ? w_a.exp  : w_b.exp;
    assign w_diff       = w_big_exp - w_small_exp;

    // Bits shifted past the round position collapse into the sticky LSB
    assign w_shift_ext = {w_small_mant, 26'b0} >> w_diff;
    assign w_small_al  = (w_diff > 8'd26) ? {26'b0, |w_small_mant}
                                          : {w_shift_ext[49:24], |w_shift_ext[23:0]};

    always_comb begin
        w_special  = 1'b1;
        w_spec_res = '0;
        if (fp_is_nan(w_a) || fp_is_nan(w_b)) begin
            w_spec_res = QNAN;
        end else if (fp_is_inf(w_a) && fp_is_inf(w_b)) begin
            w_spec_res = (w_a.sign != w_b.sign) ? QNAN : {w_a.sign, 8'hFF, 23'h0};
        end else if (fp_is_inf(w_a)) begin
            w_spec_res = {w_a.sign, 8'hFF, 23'h0};
        end else if (fp_is_inf(w_b)) begin
            w_spec_res = {w_b.sign, 8'hFF, 23'h0};
        end else if (w_a_zero && w_b_zero) begin
            w_spec_res = {w_a.sign & w_b.sign, 31'h0};
        end else begin
            w_special = 1'b0;
        end
    end

    logic r_s1_valid, r_s1_special, r_s1_sign, r_s1_sub;
    logic [31:0] r_s1_spec_res;
    logic [EXP_W-1:0] r_s1_exp;
    logic [EXT_W-1:0] r_s1_big, r_s1_small;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_s1_valid <= 1'b0;
        end else if (!w_stall) begin
            r_s1_valid <= w_ready;
        end
    end

    always_ff @(posedge aclk) begin
        if (!w_stall) begin
            r_s1_special  <= w_special;
            r_s1_spec_res <= w_spec_res;
            r_s1_sign     <= w_swap ? w_b.sign : w_a.sign;
            r_s1_sub      <= w_a.sign ^ w_b.sign;
            r_s1_exp      <= w_big_exp;
            r_s1_big      <= {w_big_mant, 3'b000};
            r_s1_small    <= w_small_al;
        end
    end

    // ---------------- Stage 2: magnitude add/subtract ----------------------
    logic [SUM_W-1:0] w_sum;
    assign w_sum = r_s1_sub ? ({1'b0, r_s1_big} - {1'b0, r_s1_small})
                            : ({1'b0, r_s1_big} + {1'b0, r_s1_small});

    logic r_s2_valid, r_s2_special, r_s2_sign;
    logic [31:0] r_s2_spec_res;
    logic [EXP_W-1:0] r_s2_exp;
    logic [SUM_W-1:0] r_s2_sum;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_s2_valid <= 1'b0;
        end else if (!w_stall) begin
            r_s2_valid <= r_s1_valid;
        end
    end

    always_ff @(posedge aclk) begin
        if (!w_stall) begin
            r_s2_special  <= r_s1_special;
            r_s2_spec_res <= r_s1_spec_res;
            r_s2_sign     <= r_s1_sign;
            r_s2_exp      <= r_s1_exp;
            r_s2_sum      <= w_sum;
        end
    end

    // ---------------- Stage 3: normalize, round, pack ----------------------
    logic [LZC_W-1:0] w_lzc;
    logic [SUM_W-1:0] w_norm;

    suma_normalizer u_normalizer (
        .i_sum  (r_s2_sum),
        .o_lzc  (w_lzc),
        .o_norm (w_norm)
    );

    logic w_round_up, w_zero_sum, w_ovf, w_unf;
    logic [MANT_W:0] w_mant_r;
    logic signed [9:0] w_exp_pre, w_exp_fin;
    logic [FRAC_W-1:0] w_frac_fin;
    logic [31:0] w_res;

    // Leading one of an unshifted sum sits one bit below the carry position
    assign w_exp_pre  = $signed({2'b00, r_s2_exp}) + 10'sd1 - $signed({5'b00000, w_lzc});
    assign w_round_up = w_norm[3] & ((|w_norm[2:0]) | w_norm[4]);
    assign w_mant_r   = {1'b0, w_norm[27:4]} + {{MANT_W{1'b0}}, w_round_up};
    assign w_exp_fin  = w_exp_pre + (w_mant_r[MANT_W] ? 10'sd1 : 10'sd0);
    assign w_frac_fin = w_mant_r[MANT_W] ? w_mant_r[23:1] : w_mant_r[22:0];
    assign w_zero_sum = (r_s2_sum == '0);
    assign w_ovf      = ~r_s2_special & ~w_zero_sum & (w_exp_fin >= 10'sd255);
    assign w_unf      = ~r_s2_special & ~w_zero_sum & (w_exp_fin <= 10'sd0);

    always_comb begin
        w_res = {r_s2_sign, w_exp_fin[7:0], w_frac_fin};
        if (r_s2_special) begin
            w_res = r_s2_spec_res;
        end else if (w_zero_sum) begin
            w_res = 32'h0000_0000;
        end else if (w_ovf) begin
            w_res = {r_s2_sign, 8'hFF, 23'h0};
        end else if (w_unf) begin
            w_res = {r_s2_sign, 31'h0};
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (!w_stall) begin
            r_out_valid <= r_s2_valid;
            r_out_data  <= w_res;
        end
    end

`ifdef SUMA_DE_LONGITUDES_FLAGS_EN
    logic w_invalid;
    logic [2:0] r_out_flags;

    assign w_invalid = r_s2_special & (r_s2_spec_res == QNAN);

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_out_flags <= '0;
        end else if (!w_stall) begin
            r_out_flags <= {w_invalid, w_ovf, w_unf};
        end
    end

    assign m_axis_result_tuser = r_out_flags;
`endif

endmodule

`default_nettype wire

// File: tb/tb_suma_de_longitudes.sv
// ============================================================================
// Module      : tb_suma_de_longitudes
// Description : Self-checking bench for suma_de_longitudes with an exact
//               big-integer binary32 addition model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_suma_de_longitudes;

    logic        aclk = 1'b0;
    logic        areset;
    logic        a_tvalid, a_tready, b_tvalid, b_tready;
    logic [31:0] a_tdata, b_tdata;
    logic        m_tvalid, m_tready;
    logic [31:0] m_tdata;
`ifdef SUMA_DE_LONGITUDES_FLAGS_EN
    logic [2:0]  m_tuser;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 aclk = ~aclk;

    suma_de_longitudes dut (
        .aclk                 (aclk),
        .areset               (areset),
        .s_axis_a_tvalid      (a_tvalid),
        .s_axis_a_tready      (a_tready),
        .s_axis_a_tdata       (a_tdata),
        .s_axis_b_tvalid      (b_tvalid),
        .s_axis_b_tready      (b_tready),
        .s_axis_b_tdata       (b_tdata),
        .m_axis_result_tvalid (m_tvalid),
        .m_axis_result_tready (m_tready),
        .m_axis_result_tdata  (m_tdata)
`ifdef SUMA_DE_LONGITUDES_FLAGS_EN
        ,
        .m_axis_result_tuser  (m_tuser)
`endif
    );

    // Exact sum as an integer count of 2^-149 units, then round to nearest even
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic sa, sb, sr;
        int ea, eb, p, sh, e;
        logic [22:0] fa, fb;
        logic [299:0] ma, mb, mag, q, rem, half;
        sa = a[31]; ea = int'(a[30:23]); fa = a[22:0];
        sb = b[31]; eb = int'(b[30:23]); fb = b[22:0];
        if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0)) return 32'h7FC00000;
        if (ea == 255 && eb == 255) return (sa == sb) ? {sa, 8'hFF, 23'h0} : 32'h7FC00000;
        if (ea == 255) return {sa, 8'hFF, 23'h0};
        if (eb == 255) return {sb, 8'hFF, 23'h0};
        ma = (ea == 0) ? '0 : (300'({1'b1, fa}) << (ea - 1));
        mb = (eb == 0) ? '0 : (300'({1'b1, fb}) << (eb - 1));
        if (ma == 0 && mb == 0) return {sa & sb, 31'h0};
        if (sa == sb) begin
            mag = ma + mb; sr = sa;
        end else if (ma >= mb) begin
            mag = ma - mb; sr = sa;
        end else begin
            mag = mb - ma; sr = sb;
        end
        if (mag == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        sh = p - 23;
        if (sh <= 0) begin
            q = mag << (-sh);
        end else begin
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = 300'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q[24]) begin
                q  = q >> 1;
                sh = sh + 1;
            end
        end
        e = sh + 1;
        if (e >= 255) return {sr, 8'hFF, 23'h0};
        if (e <= 0) return {sr, 31'h0};
        return {sr, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rand_operand(input logic [31:0] near);
        int e;
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: ;
            1: r = {~near[31], near[30:0]};
            2: r = {r[31], 8'hFF, (($urandom_range(0, 1) == 0) ? 23'h0 : r[22:0])};
            3: r = {r[31], 8'h00, r[22:0]};
            default: begin
                e = int'(near[30:23]) + int'($urandom_range(0, 60)) - 30;
                if (e < 1) e = 1;
                if (e > 254) e = 254;
                r = {r[31], e[7:0], r[22:0]};
            end
        endcase
        return r;
    endfunction

    task automatic test_reset();
        areset = 1'b1; m_tready = 1'b0;
        a_tvalid = 1'b1; b_tvalid = 1'b1;
        a_tdata = 32'h3F800000; b_tdata = 32'h3F800000;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        n_checks++; if (m_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", m_tvalid); else n_pass++;
        n_checks++; if (m_tdata !== 32'h0) $display("FAIL reset_tdata: got %08h want 00000000", m_tdata); else n_pass++;
        n_checks++; if (a_tready !== 1'b0) $display("FAIL reset_a_tready: got %b want 0", a_tready); else n_pass++;
        n_checks++; if (b_tready !== 1'b0) $display("FAIL reset_b_tready: got %b want 0", b_tready); else n_pass++;
        @(posedge aclk); #1;
        areset = 1'b0; a_tvalid = 1'b0; b_tvalid = 1'b0;
    endtask

    task automatic test_stall();
        int lat;
        m_tready = 1'b0;
        @(posedge aclk); #1;
        a_tvalid = 1'b1; b_tvalid = 1'b1;
        a_tdata = 32'hC4A42A00; b_tdata = 32'hC4A42A00;
        @(negedge aclk);
        n_checks++; if ({a_tready, b_tready} !== 2'b11) $display("FAIL stall_accept: got %b want 11", {a_tready, b_tready}); else n_pass++;
        @(posedge aclk); #1;
        a_tvalid = 1'b0; b_tvalid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge aclk);
            if (m_tvalid) begin lat = k; break; end
        end
        n_checks++; if (lat != 3) $display("FAIL stall_latency: got %0d want 3", lat); else n_pass++;
        // Offer a second pair while the first is held downstream
        a_tdata = 32'h3F800000; b_tdata = 32'h3F800000;
        a_tvalid = 1'b1; b_tvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge aclk);
            n_checks++; if (m_tvalid !== 1'b1) $display("FAIL stall_hold_valid: got %b want 1", m_tvalid); else n_pass++;
            n_checks++; if (m_tdata !== 32'hC5242A00) $display("FAIL stall_hold_data: got %08h want C5242A00", m_tdata); else n_pass++;
            n_checks++; if ({a_tready, b_tready} !== 2'b00) $display("FAIL stall_tready: got %b want 00", {a_tready, b_tready}); else n_pass++;
        end
        @(posedge aclk); #1;
        m_tready = 1'b1;
        @(negedge aclk);
        n_checks++; if ({a_tready, b_tready} !== 2'b11) $display("FAIL stall_release_ready: got %b want 11", {a_tready, b_tready}); else n_pass++;
        @(posedge aclk); #1;
        a_tvalid = 1'b0; b_tvalid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge aclk);
            if (m_tvalid) begin lat = k; break; end
        end
        n_checks++; if (lat != 3) $display("FAIL stall_second_latency: got %0d want 3", lat); else n_pass++;
        n_checks++; if (m_tdata !== 32'h40000000) $display("FAIL stall_second_data: got %08h want 40000000", m_tdata); else n_pass++;
    endtask

    task automatic test_specials();
        logic [31:0] ta [12];
        logic [31:0] tb_op [12];
        logic [31:0] tr [12];
`ifdef SUMA_DE_LONGITUDES_FLAGS_EN
        logic [2:0]  tf [12];
`endif
        int lat;
        ta    = '{32'h3F800000, 32'h7F800000, 32'h7F7FFFFF, 32'h3F800000, 32'h3F800000, 32'h80000000,
                  32'h7FC00001, 32'h7F800000, 32'hFF800000, 32'h00400000, 32'h00800000, 32'h00C00000};
        tb_op = '{32'hBF800000, 32'hFF800000, 32'h7F7FFFFF, 32'h33800000, 32'h34000000, 32'h80000000,
                  32'h3F800000, 32'h3F800000, 32'hFF800000, 32'h00000000, 32'h80400000, 32'h80800000};
        tr    = '{32'h00000000, 32'h7FC00000, 32'h7F800000, 32'h3F800000, 32'h3F800001, 32'h80000000,
                  32'h7FC00000, 32'h7F800000, 32'hFF800000, 32'h00000000, 32'h00800000, 32'h00000000};
`ifdef SUMA_DE_LONGITUDES_FLAGS_EN
        tf    = '{3'b000, 3'b100, 3'b010, 3'b000, 3'b000, 3'b000,
                  3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001};
`endif
        m_tready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge aclk); #1;
            a_tvalid = 1'b1; b_tvalid = 1'b1;
            a_tdata = ta[i]; b_tdata = tb_op[i];
            @(posedge aclk); #1;
            a_tvalid = 1'b0; b_tvalid = 1'b0;
            lat = 0;
            for (int k = 1; k <= 8; k++) begin
                @(negedge aclk);
                if (m_tvalid) begin lat = k; break; end
            end
            n_checks++; if (lat != 3) $display("FAIL special_latency[%0d]: got %0d want 3", i, lat); else n_pass++;
            n_checks++; if (m_tdata !== tr[i]) $display("FAIL special_data[%0d] %08h+%08h: got %08h want %08h", i, ta[i], tb_op[i], m_tdata, tr[i]); else n_pass++;
`ifdef SUMA_DE_LONGITUDES_FLAGS_EN
            n_checks++; if (m_tuser !== tf[i]) $display("FAIL special_flags[%0d]: got %b want %b", i, m_tuser, tf[i]); else n_pass++;
`endif
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pa [6];
        logic [31:0] pb [6];
        int got;
        m_tready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pa[i] = {1'($urandom_range(0, 1)), 8'(120 + $urandom_range(0, 15)), 23'($urandom)};
            pb[i] = {1'($urandom_range(0, 1)), 8'(120 + $urandom_range(0, 15)), 23'($urandom)};
        end
        got = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge aclk); #1;
            if (c < 6) begin
                a_tvalid = 1'b1; b_tvalid = 1'b1; a_tdata = pa[c]; b_tdata = pb[c];
            end else begin
                a_tvalid = 1'b0; b_tvalid = 1'b0;
            end
            @(negedge aclk);
            if (c < 6) begin
                n_checks++; if ({a_tready, b_tready} !== 2'b11) $display("FAIL b2b_ready[%0d]: got %b want 11", c, {a_tready, b_tready}); else n_pass++;
            end
            if (m_tvalid) begin
                n_checks++;
                if (got >= 6 || c - 3 != got) $display("FAIL b2b_timing: result %0d in cycle %0d, want cycle %0d", got, c, got + 3);
                else n_pass++;
                if (got < 6) begin
                    n_checks++;
                    if (m_tdata !== ref_add(pa[got], pb[got])) $display("FAIL b2b_data[%0d]: got %08h want %08h", got, m_tdata, ref_add(pa[got], pb[got]));
                    else n_pass++;
                end
                got++;
            end
        end
        n_checks++; if (got != 6) $display("FAIL b2b_count: got %0d want 6", got); else n_pass++;
    endtask

    task automatic test_reset_flush();
        m_tready = 1'b1;
        @(posedge aclk); #1;
        a_tvalid = 1'b1; b_tvalid = 1'b1; a_tdata = 32'h3F800000; b_tdata = 32'h3F800000;
        @(posedge aclk); #1;
        a_tdata = 32'h40000000; b_tdata = 32'h40000000;
        @(posedge aclk); #1;
        areset = 1'b1;
        @(negedge aclk);
        n_checks++; if ({a_tready, b_tready} !== 2'b00) $display("FAIL flush_ready_in_reset: got %b want 00", {a_tready, b_tready}); else n_pass++;
        @(posedge aclk); #1;
        areset = 1'b0; a_tvalid = 1'b0; b_tvalid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge aclk);
            n_checks++; if (m_tvalid !== 1'b0) $display("FAIL flush_stale[%0d]: got tvalid %b want 0", k, m_tvalid); else n_pass++;
        end
    endtask

    task automatic test_random(input int n);
        logic [31:0] q_exp [$];
        logic [31:0] pa, pb, want;
        logic pending, exp_ready;
        int sent, recv, cyc;
        pending = 1'b0; sent = 0; recv = 0; cyc = 0;
        pa = '0; pb = '0;
        while (recv < n && cyc < n * 20 + 200) begin
            @(posedge aclk); #1;
            if (!pending && sent < n && $urandom_range(0, 3) != 0) begin
                pa = rand_operand($urandom);
                pb = rand_operand(pa);
                pending = 1'b1;
            end
            if (pending) begin
                a_tdata = pa; b_tdata = pb;
                a_tvalid = ($urandom_range(0, 4) != 0);
                b_tvalid = ($urandom_range(0, 4) != 0);
            end else begin
                a_tdata = $urandom; b_tdata = $urandom;
                a_tvalid = 1'b0; b_tvalid = 1'b0;
            end
            m_tready = ($urandom_range(0, 2) != 0);
            @(negedge aclk);
            exp_ready = a_tvalid & b_tvalid & ~(m_tvalid & ~m_tready);
            n_checks++;
            if ({a_tready, b_tready} !== {exp_ready, exp_ready}) $display("FAIL rand_tready: got %b want %b%b", {a_tready, b_tready}, exp_ready, exp_ready);
            else n_pass++;
            if (exp_ready) begin
                q_exp.push_back(ref_add(pa, pb));
                pending = 1'b0;
                sent++;
            end
            if (m_tvalid && m_tready) begin
                n_checks++;
                if (q_exp.size() == 0) begin
                    $display("FAIL rand_unexpected: got result %08h with none pending", m_tdata);
                end else begin
                    want = q_exp.pop_front();
                    if (m_tdata !== want) $display("FAIL rand_data[%0d]: got %08h want %08h", recv, m_tdata, want);
                    else n_pass++;
                end
                recv++;
            end
            cyc++;
        end
        @(posedge aclk); #1;
        a_tvalid = 1'b0; b_tvalid = 1'b0;
        n_checks++; if (recv != n) $display("FAIL rand_timeout: received %0d want %0d", recv, n); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stall();
        test_specials();
        test_back_to_back();
        test_reset_flush();
        test_random(400);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/suma_de_longitudes.md
SUMA_DE_LONGITUDES -- requirements
Module: suma_de_longitudes

Interface
REQ-001 SHALL have no parameters; latency, widths and format are fixed.
REQ-002 SHALL have port: aclk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port: areset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: s_axis_a_tvalid  input  1  operand A valid.
REQ-005 SHALL have port: s_axis_a_tready  output  1  operand A accepted.
REQ-006 SHALL have port: s_axis_a_tdata  input  32  operand A, IEEE-754 binary32.
REQ-007 SHALL have port: s_axis_b_tvalid  input  1  operand B valid.
REQ-008 SHALL have port: s_axis_b_tready  output  1  operand B accepted.
REQ-009 SHALL have port: s_axis_b_tdata  input  32  operand B, IEEE-754 binary32.
REQ-010 SHALL have port: m_axis_result_tvalid  output  1  sum valid.
REQ-011 SHALL have port: m_axis_result_tready  input  1  downstream ready.
REQ-012 SHALL have port: m_axis_result_tdata  output  32  A+B, binary32.

Function
REQ-013 SHALL compute one binary32 sum A+B per accepted operand pair.
REQ-014 SHALL treat A and B as one joint transfer, so neither operand is consumed alone.
REQ-015 SHALL compute stall = m_axis_result_tvalid AND NOT m_axis_result_tready.
REQ-016 SHALL drive both tready outputs equal to s_axis_a_tvalid AND s_axis_b_tvalid AND NOT stall AND NOT areset.
REQ-017 SHALL accept a pair on a cycle where both tvalid and both tready are high.
REQ-018 SHALL present the result on m_axis_result_tvalid/tdata exactly 3 cycles after acceptance when not stalled.
REQ-019 SHALL implement a 3-stage pipeline (align, add, normalize/round) that holds all stages while stall is high.
REQ-020 SHALL sustain one result per cycle when never stalled.
REQ-021 SHALL hold m_axis_result_tdata stable while tvalid is high and tready is low.
REQ-022 SHALL round to nearest, ties to even.
REQ-023 SHALL flush subnormal inputs to signed zero and tiny results to signed zero.
REQ-024 SHALL return +0 for x+(-x) and -0 for (-0)+(-0).
REQ-025 SHALL return signed infinity on overflow.
REQ-026 SHALL return inf for inf+finite, same-sign inf for inf+inf, and canonical qNaN 0x7FC00000 for inf+(-inf) or any NaN input.
REQ-027 SHALL use a guard/round/sticky datapath of at least 27 significand bits plus carry.

Reset
REQ-028 SHALL clear m_axis_result_tvalid, every pipeline valid bit and m_axis_result_tdata to 0 on the edge where areset is high.
REQ-029 SHALL hold both tready outputs at 0 while areset is high.
REQ-030 SHALL discard in-flight operations on reset mid-operation, with no result emitted afterwards.

Configuration
REQ-031 SHALL, with macro SUMA_DE_LONGITUDES_FLAGS_EN defined, add output m_axis_result_tuser[2:0] = {invalid, overflow, underflow}, aligned with tdata and reset to 0.
REQ-032 SHALL, without SUMA_DE_LONGITUDES_FLAGS_EN, omit the tuser port and its flag logic, with tdata behaviour identical.

Structure
REQ-033 SHALL place the exponent width 8, fraction width 23, bias 127, latency 3 and the QNAN constant 0x7FC00000 in shared package suma_pkg.
REQ-034 SHALL implement leading-zero count and normalizing shift in one sub-module, suma_normalizer.

Verification
REQ-035 SHALL verify: A=B=0xC4A42A00, both valid, m_tready=0 -> one pair accepted, tvalid high 3 cycles later, tdata 0xC5242A00 held, both tready low; then m_tready=1 -> transfer completes.
REQ-036 SHALL verify: 0x3F800000+0xBF800000 -> 0x00000000; 0x7F800000+0xFF800000 -> 0x7FC00000, invalid flag set when enabled.
REQ-037 SHALL verify: 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000, overflow flag set when enabled.
REQ-038 SHALL verify: 0x3F800000+0x33800000 -> 0x3F800000 (tie to even); 0x3F800000+0x34000000 -> 0x3F800001.
REQ-039 SHALL verify: back-to-back pairs with m_tready=1 -> one result per cycle, in order, at 3-cycle latency.
REQ-040 SHALL verify: areset asserted with 2 operations in flight -> tvalid 0 on the next cycle, no stale result after release.
